text_cell_reader: RTL and testbench

Scan-out reader for the TextGraphic character cell memory. It consumes the 18-bit cell words `{BL[1:0], BG[3:0], FG[3:0], Char[7:0]}` that the core writer stores at `WAddr = row*COLS + col`. It tracks the raster position from start-of-frame and start-of-line strobes, reads the cell RAM and font ROM through synchronous read ports, and emits a 4-bit palette index per pixel with blink and inverse attributes applied. It sits between the cell/font memories and the TMDS encoder front end.

---
 rtl/text_cell_reader.sv | 245 ++++++++++++++++++++++++
 tb/tb_text_cell_reader.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/text_cell_reader.sv
// text_cell_reader: raster scan-out of the text cell memory.
// Follows sof/sol strobes to track the glyph position, reads the cell RAM and
// font ROM through registered addresses, and emits one palette index per
// requested pixel with blink/inverse attributes applied.
// Optional cursor overlay: define XRC_TEXT_CURSOR_EN.
//
// Handshake: pix_en is a one-cycle request with no back-pressure. Every cycle
// with pix_en=1 launches exactly one token. That token appears as exactly one
// cycle of pix_valid=1 three cycles later, together with pix_color/pix_fg.
// pix_valid has no ready. Tokens still in flight are dropped by reset.
`timescale 1ns/1ps

module text_cell_reader #(
    parameter int COLS   = 120,
    parameter int ROWS   = 61,
    parameter int CHAR_H = 16
) (
    input  logic        clk50,
    input  logic        reset,
    input  logic        sof,
    input  logic        sol,
    input  logic        pix_en,
    output logic [12:0] RAddr,
    input  logic [17:0] RData,
    output logic [11:0] FAddr,
    input  logic [7:0]  FData,
    input  logic [12:0] cur_addr,
    input  logic        cur_on,
    output logic        pix_valid,
    output logic [3:0]  pix_color,
    output logic        pix_fg
);

    localparam logic [12:0] COLS13  = 13'(COLS);
    localparam logic [12:0] ROWS13  = 13'(ROWS);
    localparam logic [3:0]  GY_LAST = 4'(CHAR_H - 1);

    // raster position registers
    logic [2:0]  px_q;
    logic [12:0] col_q;
    logic [3:0]  gy_q;
    logic [12:0] row_q;
    logic [12:0] rb_q;
    logic [5:0]  frame_q;
    logic        first_q;   // still in the line started by sof

    // position after this cycle's strobes (what a coinciding pixel uses)
    logic [2:0]  eff_px;
    logic [12:0] eff_col;
    logic [3:0]  eff_gy;
    logic [12:0] eff_row;
    logic [12:0] eff_rb;
    logic [5:0]  eff_frame;
    logic        eff_first;
    logic [2:0]  nxt_px;
    logic [12:0] nxt_col;

    logic [12:0] s0_addr;
    logic        s0_inr;
    logic        s0_cur;

    // S1 token
    logic        s1_valid;
    logic [2:0]  s1_px;
    logic [3:0]  s1_gy;
    logic        s1_inr;
    logic        s1_cur;
    logic [1:0]  s1_blink;

    // S2 token
    logic        s2_valid;
    logic [2:0]  s2_px;
    logic        s2_inr;
    logic        s2_cur;
    logic [1:0]  s2_blink;
    logic [1:0]  s2_bl;
    logic [3:0]  s2_bg;
    logic [3:0]  s2_fg;

    logic        s2_glyph;
    logic        s2_fg_bit;
    logic [3:0]  s2_color;

    // Apply sof/sol to the position, then advance by one pixel if requested.
    always_comb begin
        eff_px    = px_q;
        eff_col   = col_q;
        eff_gy    = gy_q;
        eff_row   = row_q;
        eff_rb    = rb_q;
        eff_frame = frame_q;
        eff_first = first_q;
        if (sof) begin
            eff_px    = 3'd0;
            eff_col   = 13'd0;
            eff_gy    = 4'd0;
            eff_row   = 13'd0;
            eff_rb    = 13'd0;
            eff_frame = frame_q + 6'd1;
            eff_first = 1'b1;
        end else if (sol) begin
            eff_px  = 3'd0;
            eff_col = 13'd0;
            if (first_q) begin
                // sof already put us on line 0; this sol only opens it
                eff_first = 1'b0;
            end else if (gy_q == GY_LAST) begin
                eff_gy = 4'd0;
                if (row_q < ROWS13) begin
                    eff_row = row_q + 13'd1;
                    eff_rb  = rb_q + COLS13;
                end
            end else begin
                eff_gy = gy_q + 4'd1;
            end
        end

        nxt_px  = eff_px;
        nxt_col = eff_col;
        if (pix_en) begin
            nxt_px = eff_px + 3'd1;
            if (eff_px == 3'd7 && eff_col != COLS13) begin
                nxt_col = eff_col + 13'd1;
            end
        end
    end

    assign s0_addr = eff_rb + eff_col;
    assign s0_inr  = (eff_col < COLS13) && (eff_row < ROWS13);

`ifdef XRC_TEXT_CURSOR_EN
    localparam logic [3:0] GY_CUR = 4'(CHAR_H - 2);
    assign s0_cur = cur_on && (s0_addr == cur_addr) && (eff_gy >= GY_CUR) && eff_frame[4];
`else
    logic unused_cursor;
    assign s0_cur        = 1'b0;
    assign unused_cursor = &{1'b0, cur_addr, cur_on};
`endif

    // Position state register.
    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            px_q    <= 3'd0;
            col_q   <= 13'd0;
            gy_q    <= 4'd0;
            row_q   <= 13'd0;
            rb_q    <= 13'd0;
            frame_q <= 6'd0;
            first_q <= 1'b0;
        end else begin
            px_q    <= nxt_px;
            col_q   <= nxt_col;
            gy_q    <= eff_gy;
            row_q   <= eff_row;
            rb_q    <= eff_rb;
            frame_q <= eff_frame;
            first_q <= eff_first;
        end
    end

    // S0: launch a token and register the cell RAM address.
    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            RAddr    <= 13'd0;
            s1_valid <= 1'b0;
            s1_px    <= 3'd0;
            s1_gy    <= 4'd0;
            s1_inr   <= 1'b0;
            s1_cur   <= 1'b0;
            s1_blink <= 2'd0;
        end else begin
            s1_valid <= pix_en;
            if (pix_en) begin
                RAddr    <= s0_addr;
                s1_px    <= eff_px;
                s1_gy    <= eff_gy;
                s1_inr   <= s0_inr;
                s1_cur   <= s0_cur;
                s1_blink <= eff_frame[5:4];
            end
        end
    end

    // S1: capture the cell word and register the font ROM address.
    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            FAddr    <= 12'd0;
            s2_valid <= 1'b0;
            s2_px    <= 3'd0;
            s2_inr   <= 1'b0;
            s2_cur   <= 1'b0;
            s2_blink <= 2'd0;
            s2_bl    <= 2'd0;
            s2_bg    <= 4'd0;
            s2_fg    <= 4'd0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                FAddr    <= {RData[7:0], s1_gy};
                s2_bl    <= RData[17:16];
                s2_bg    <= RData[15:12];
                s2_fg    <= RData[11:8];
                s2_px    <= s1_px;
                s2_inr   <= s1_inr;
                s2_cur   <= s1_cur;
                s2_blink <= s1_blink;
            end
        end
    end

    // S2: pick the glyph bit and apply blink/inverse/cursor/range.
    always_comb begin
        s2_glyph  = FData[3'd7 - s2_px];
        s2_fg_bit = s2_glyph;
        s2_color  = 4'd0;
        case (s2_bl)
            2'b01:   s2_fg_bit = s2_glyph & ~s2_blink[1];
            2'b10:   s2_fg_bit = s2_glyph & ~s2_blink[0];
            2'b11:   s2_fg_bit = ~s2_glyph;
            default: s2_fg_bit = s2_glyph;
        endcase
        if (s2_cur) begin
            s2_fg_bit = 1'b1;
        end
        if (!s2_inr) begin
            s2_fg_bit = 1'b0;
        end else begin
            s2_color = s2_fg_bit ? s2_fg : s2_bg;
        end
    end

    // Output register; color/fg are zero whenever no pixel is valid.
    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            pix_valid <= 1'b0;
            pix_color <= 4'd0;
            pix_fg    <= 1'b0;
        end else begin
            pix_valid <= s2_valid;
            pix_color <= s2_valid ? s2_color : 4'd0;
            pix_fg    <= s2_valid & s2_fg_bit;
        end
    end

endmodule

// File: tb/tb_text_cell_reader.sv
// Directed bench for text_cell_reader: cell RAM and font ROM modelled as
// arrays read through the DUT's registered addresses; pixels collected on the
// falling edge and compared against hand-computed colors.
`timescale 1ns/1ps

module tb_text_cell_reader;

    logic        clk50 = 1'b0;
    logic        reset;
    logic        sof;
    logic        sol;
    logic        pix_en;
    logic [12:0] RAddr;
    logic [17:0] RData;
    logic [11:0] FAddr;
    logic [7:0]  FData;
    logic [12:0] cur_addr;
    logic        cur_on;
    logic        pix_valid;
    logic [3:0]  pix_color;
    logic        pix_fg;

    logic [17:0] cell_mem [0:8191];
    logic [7:0]  font_mem [0:4095];

    logic [3:0]  got_color[$];
    logic        got_fg[$];
    logic [3:0]  exp_q[$];

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [5:0]  fc_model;

    text_cell_reader #(.COLS(120), .ROWS(61), .CHAR_H(16)) dut (
        .clk50(clk50), .reset(reset), .sof(sof), .sol(sol), .pix_en(pix_en),
        .RAddr(RAddr), .RData(RData), .FAddr(FAddr), .FData(FData),
        .cur_addr(cur_addr), .cur_on(cur_on),
        .pix_valid(pix_valid), .pix_color(pix_color), .pix_fg(pix_fg)
    );

    // clock / memories
    always #5 clk50 = ~clk50;
    assign RData = cell_mem[RAddr];
    assign FData = font_mem[FAddr];

    // output capture, away from the active edge
    always @(negedge clk50) begin
        if (pix_valid) begin
            got_color.push_back(pix_color);
            got_fg.push_back(pix_fg);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk50);
        #1;
    endtask

    task automatic step(input logic s_sof, input logic s_sol, input logic s_pen);
        sof    = s_sof;
        sol    = s_sol;
        pix_en = s_pen;
        tick();
        sof    = 1'b0;
        sol    = 1'b0;
        pix_en = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic clear_q();
        got_color.delete();
        got_fg.delete();
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) cell_mem[i] = 18'd0;
        for (int i = 0; i < 4096; i++) font_mem[i] = 8'd0;
        reset = 1'b1; sof = 1'b0; sol = 1'b0; pix_en = 1'b0;
        cur_addr = 13'd5; cur_on = 1'b0;
        fc_model = 6'd0;

        // ---------- reset state ----------
        repeat (3) tick();
        check("rst_raddr", 32'(RAddr), 32'h0);
        check("rst_faddr", 32'(FAddr), 32'h0);
        check("rst_valid", 32'(pix_valid), 32'h0);
        check("rst_color", 32'(pix_color), 32'h0);
        check("rst_fg", 32'(pix_fg), 32'h0);
        reset = 1'b0;
        tick();

        // ---------- basic cell: BL0 BG2 FG1 'A', bitmap A5 ----------
        cell_mem[0]      = 18'h02141;
        font_mem[12'h410] = 8'hA5;
        clear_q();
        step(1'b1, 1'b0, 1'b0);
        fc_model++;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b0, 1'b1);
            check("t1_raddr", 32'(RAddr), 32'h0);
            check("t1_valid_lat", 32'(pix_valid), (i >= 2) ? 32'h1 : 32'h0);
            if (i >= 1) check("t1_faddr", 32'(FAddr), 32'h410);
        end
        idle(3);
        exp_q = '{4'd1, 4'd2, 4'd1, 4'd2, 4'd2, 4'd1, 4'd2, 4'd1};
        check("t1_count", 32'(got_color.size()), 32'd8);
        for (int i = 0; i < 8; i++) begin
            check("t1_color", 32'(got_color[i]), 32'(exp_q[i]));
            check("t1_fg", 32'(got_fg[i]), (exp_q[i] == 4'd1) ? 32'h1 : 32'h0);
        end

        // ---------- row advance and column overflow ----------
        cell_mem[119]     = 18'h03400;   // BG3 FG4 char 00 -> blank glyph -> 3
        cell_mem[120]     = 18'h05642;   // row 1 col 0: BG5 FG6 char 42
        font_mem[12'h420] = 8'hFF;
        step(1'b1, 1'b0, 1'b0);
        fc_model++;
        for (int ln = 0; ln < 16; ln++) begin
            clear_q();
            step(1'b0, 1'b1, 1'b0);
            for (int p = 0; p < ((ln == 0) ? 961 : 960); p++) begin
                step(1'b0, 1'b0, 1'b1);
                if (p == 1 && ln == 15) check("t2_faddr_gy15", 32'(FAddr), 32'h41F);
            end
            idle(3);
            if (ln == 0) begin
                check("t2_line_count", 32'(got_color.size()), 32'd961);
                check("t2_last_col", 32'(got_color[959]), 32'h3);
                check("t2_oor_color", 32'(got_color[960]), 32'h0);
                check("t2_oor_fg", 32'(got_fg[960]), 32'h0);
            end
        end
        clear_q();
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        check("t2_row1_raddr", 32'(RAddr), 32'd120);
        step(1'b0, 1'b0, 1'b0);
        check("t2_row1_faddr", 32'(FAddr), 32'h420);
        idle(2);
        check("t2_row1_color", 32'(got_color[0]), 32'h6);

        // ---------- blink over a full frame_cnt cycle ----------
        cell_mem[0]       = 18'h12141;   // slow blink, BG2 FG1
        cell_mem[1]       = 18'h23441;   // fast blink, BG3 FG4
        cell_mem[2]       = 18'h37843;   // inverse, BG7 FG8
        font_mem[12'h430] = 8'hFF;
        for (int f = 0; f < 64; f++) begin
            clear_q();
            step(1'b1, 1'b0, 1'b1);
            repeat (8) step(1'b0, 1'b0, 1'b1);
            idle(3);
            fc_model++;
            check("t3_slow_blink", 32'(got_color[0]), fc_model[5] ? 32'h2 : 32'h1);
            check("t3_fast_blink", 32'(got_color[8]), fc_model[4] ? 32'h3 : 32'h4);
        end
        clear_q();
        step(1'b1, 1'b0, 1'b0);
        fc_model++;
        repeat (24) step(1'b0, 1'b0, 1'b1);
        idle(3);
        for (int k = 16; k < 24; k++) begin
            check("t3_inverse_color", 32'(got_color[k]), 32'h7);
            check("t3_inverse_fg", 32'(got_fg[k]), 32'h0);
        end

        // ---------- sof+sol+pix_en together, mid-frame ----------
        while (fc_model != 6'd29) begin
            step(1'b1, 1'b0, 1'b0);
            fc_model++;
        end
        step(1'b1, 1'b0, 1'b0);
        fc_model++;                      // 30
        repeat (3) step(1'b0, 1'b1, 1'b0);
        repeat (20) step(1'b0, 1'b0, 1'b1);
        idle(3);
        clear_q();
        step(1'b1, 1'b1, 1'b1);
        fc_model++;                      // 31
        check("t4_raddr", 32'(RAddr), 32'h0);
        step(1'b0, 1'b0, 1'b0);
        check("t4_faddr_gy0", 32'(FAddr), 32'h410);
        idle(2);
        check("t4_frame_31", 32'(got_color[0]), 32'h1);
        clear_q();
        step(1'b1, 1'b0, 1'b1);
        fc_model++;                      // 32
        idle(3);
        check("t4_frame_32", 32'(got_color[0]), 32'h2);

        // ---------- reset with two tokens in flight ----------
        clear_q();
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        check("t5_pre_valid", 32'(pix_valid), 32'h0);
        reset = 1'b1;
        #1;
        check("t5_rst_valid", 32'(pix_valid), 32'h0);
        check("t5_rst_raddr", 32'(RAddr), 32'h0);
        check("t5_rst_faddr", 32'(FAddr), 32'h0);
        repeat (3) tick();
        reset = 1'b0;
        fc_model = 6'd0;
        idle(6);
        check("t5_no_output", 32'(got_color.size()), 32'd0);

        // ---------- cursor on bottom glyph rows of cell 5 ----------
        cell_mem[5]       = 18'h02941;   // BG2 FG9 'A'
        font_mem[12'h41F] = 8'h81;
        cur_on   = 1'b1;
        cur_addr = 13'd5;
        repeat (16) begin
            step(1'b1, 1'b0, 1'b0);
            fc_model++;
        end
        repeat (16) step(1'b0, 1'b1, 1'b0);   // gy reaches 15
        clear_q();
        repeat (48) step(1'b0, 1'b0, 1'b1);
        idle(3);
`ifdef XRC_TEXT_CURSOR_EN
        exp_q = '{4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9};
`else
        exp_q = '{4'd9, 4'd2, 4'd2, 4'd2, 4'd2, 4'd2, 4'd2, 4'd9};
`endif
        check("t6_count", 32'(got_color.size()), 32'd48);
        for (int k = 0; k < 8; k++) begin
            check("t6_cursor_color", 32'(got_color[40 + k]), 32'(exp_q[k]));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
